// File: rtl/instruction_fetch_if.sv
// Fetch-stage bundle: ROM address/data, redirect request and decoder handshake.
// The master side is the fetch unit; the slave side is the ROM/decoder/branch
// environment around it.
interface instruction_fetch_if #(
    parameter int DATA_WIDTH = 32
);
    // ROM side
    logic [DATA_WIDTH-1:0] Address_o;
    logic [DATA_WIDTH-1:0] Instruction_i;

    // Branch/jump redirect
    logic                  Redirect_i;
    logic [DATA_WIDTH-1:0] Target_i;

    // Decoder side
    logic                  Instr_valid_o;
    logic                  Instr_ready_i;
    logic [DATA_WIDTH-1:0] Instruction_o;
    logic [DATA_WIDTH-1:0] Pc_o;
    logic                  Fault_o;

    modport master (
        output Address_o,
        input  Instruction_i,
        input  Redirect_i,
        input  Target_i,
        output Instr_valid_o,
        input  Instr_ready_i,
        output Instruction_o,
        output Pc_o,
        output Fault_o
    );

    modport slave (
        input  Address_o,
        output Instruction_i,
        output Redirect_i,
        output Target_i,
        input  Instr_valid_o,
        output Instr_ready_i,
        input  Instruction_o,
        input  Pc_o,
        input  Fault_o
    );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: PC register plus a 2-entry {PC, instruction} FIFO in
// front of the decoder. The ROM is read combinationally at Address_o (= PC) and
// the word is captured into the FIFO, so a fetched word reaches the decoder one
// cycle later at the earliest. Push and pop may happen together, giving one
// instruction per cycle; a redirect flushes the FIFO and reloads the PC.
//
// Optional feature macro: FETCH_BOUNDS_CHECK_EN
//   defined   : a PC outside [RESET_PC, RESET_PC + 4*MEMORY_DEPTH) stops
//               fetching and raises a sticky Fault_o until reset or a redirect
//               to an in-range target; entries already in the FIFO still drain.
//   undefined : Fault_o stays 0 and every PC is fetched (the ROM only decodes
//               the low address bits).
module instruction_fetch #(
    parameter int                    MEMORY_DEPTH = 64,
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC     = 32'h0040_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    instruction_fetch_if.master   bus
);

    // FIFO geometry
    localparam int FIFO_DEPTH = 2;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);

`ifdef FETCH_BOUNDS_CHECK_EN
    localparam logic BOUNDS_CHECK = 1'b1;
`else
    localparam logic BOUNDS_CHECK = 1'b0;
`endif

    // ROM window, one bit wider so the upper bound cannot overflow
    localparam logic [DATA_WIDTH:0] ROM_LO = {1'b0, RESET_PC};
    localparam logic [DATA_WIDTH:0] ROM_HI = ROM_LO + (DATA_WIDTH+1)'(4 * MEMORY_DEPTH);

    // True when a byte address falls inside the instruction ROM
    function automatic logic in_rom(input logic [DATA_WIDTH-1:0] addr);
        logic [DATA_WIDTH:0] a;
        a = {1'b0, addr};
        return (a >= ROM_LO) && (a < ROM_HI);
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] pc_q,  pc_d;
    logic [1:0]            count_q, count_d;
    logic                  fault_q, fault_d;

    // Slot 0 is always the head; slot 1 is the entry behind it
    logic [DATA_WIDTH-1:0] slot_pc_q  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] slot_pc_d  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] slot_ins_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] slot_ins_d [FIFO_DEPTH];

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic                  head_valid;
    logic                  pop;
    logic                  push;
    logic                  pc_blocked;
    logic [PTR_W-1:0]      wr_slot;
    logic [DATA_WIDTH-1:0] redirect_pc;

    // Decide this cycle's push/pop and where a pushed entry lands
    always_comb begin
        head_valid  = (count_q != 2'd0);
        pop         = head_valid && bus.Instr_ready_i;
        pc_blocked  = BOUNDS_CHECK && !in_rom(pc_q);
        // A full FIFO can still accept when the head leaves in the same cycle
        push        = !bus.Redirect_i && !pc_blocked
                      && ((count_q < 2'd2) || pop);
        // After a pop the survivors shift down, so the free slot is count-pop
        wr_slot     = PTR_W'(count_q - {1'b0, pop});
        // Instructions are word aligned; low target bits are dropped
        redirect_pc = bus.Target_i & ~DATA_WIDTH'(3);
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------

    // Compute next PC, FIFO contents, occupancy and fault flag
    always_comb begin
        pc_d    = pc_q;
        count_d = count_q;
        fault_d = fault_q;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            slot_pc_d[i]  = slot_pc_q[i];
            slot_ins_d[i] = slot_ins_q[i];
        end

        if (bus.Redirect_i) begin
            // Redirect wins: drop everything queued (a head accepted this
            // cycle is simply gone) and restart fetching at the target
            pc_d    = redirect_pc;
            count_d = 2'd0;
            fault_d = BOUNDS_CHECK && !in_rom(redirect_pc);
        end else begin
            if (pop) begin
                // Shift toward the head; the wrapped copy into the last slot
                // lies beyond the occupancy and is never observed
                for (int i = 0; i < FIFO_DEPTH; i++) begin
                    slot_pc_d[i]  = slot_pc_q[(i + 1) % FIFO_DEPTH];
                    slot_ins_d[i] = slot_ins_q[(i + 1) % FIFO_DEPTH];
                end
            end

            if (push) begin
                slot_pc_d[wr_slot]  = pc_q;
                slot_ins_d[wr_slot] = bus.Instruction_i;
                // Natural modulo-2^DATA_WIDTH wrap
                pc_d                = pc_q + DATA_WIDTH'(4);
            end

            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase

            // Sticky until reset or an in-range redirect
            if (pc_blocked) begin
                fault_d = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------

    // State update; reset also discards any redirect presented with it
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            count_q <= 2'd0;
            fault_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                slot_pc_q[i]  <= '0;
                slot_ins_q[i] <= '0;
            end
        end else begin
            pc_q    <= pc_d;
            count_q <= count_d;
            fault_q <= fault_d;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                slot_pc_q[i]  <= slot_pc_d[i];
                slot_ins_q[i] <= slot_ins_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.Address_o     = pc_q;
    assign bus.Instr_valid_o = head_valid;
    // Head fields read as zero whenever nothing is presented
    assign bus.Instruction_o = head_valid ? slot_ins_q[0] : '0;
    assign bus.Pc_o          = head_valid ? slot_pc_q[0]  : '0;
    assign bus.Fault_o       = fault_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: behavioural ROM, directed scenarios with
// cycle-exact checks, plus an in-order scoreboard that is reloaded with the
// expected fetch stream whenever reset or a redirect is driven and is popped
// on every decoder handshake.
module tb_instruction_fetch;

    localparam logic [31:0] RESET_PC = 32'h0040_0000;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    instruction_fetch_if #(.DATA_WIDTH(32)) bus();

    // 64-word ROM decoding address bits [7:2]
    logic [31:0] rom [64];
    assign bus.Instruction_i = rom[bus.Address_o[7:2]];

    instruction_fetch #(
        .MEMORY_DEPTH (64),
        .DATA_WIDTH   (32),
        .RESET_PC     (RESET_PC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int pops   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard of the expected in-order instruction stream
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    function automatic void sb_load(input logic [31:0] start);
        logic [31:0] a;
        sb_q.delete();
        for (int i = 0; i < 256; i++) begin
            a = start + 32'(4 * i);
            sb_q.push_back({a, rom[a[7:2]]});
        end
    endfunction

    // Compare each accepted head against the stream, then apply reset/redirect
    always @(negedge clk) begin
        if (reset !== 1'b0) begin
            sb_load(RESET_PC);
        end else begin
            if (bus.Instr_valid_o && bus.Instr_ready_i) begin
                if (sb_q.size() == 0) begin
                    check("sb_underflow", 32'd0, 32'd1);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("sb_pc", bus.Pc_o, mon_e.pc);
                    check("sb_instr", bus.Instruction_o, mon_e.ins);
                    pops++;
                    $display("pop pc=%h instr=%h", bus.Pc_o, bus.Instruction_o);
                end
            end
            if (bus.Redirect_i) begin
                sb_load(bus.Target_i & ~32'd3);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 64; i++) begin
            rom[i] = 32'hA500_0000 | 32'(i);
        end
        rom[0] = 32'h2008_ffff;
        rom[1] = 32'h2009_0010;
        rom[2] = 32'h200a_000a;
        rom[3] = 32'h200b_0019;
        rom[4] = 32'h012a_8020;
        rom[5] = 32'h0168_8820;

        bus.Redirect_i    = 1'b0;
        bus.Target_i      = 32'd0;
        bus.Instr_ready_i = 1'b1;
        reset             = 1'b1;

        // Reset for two cycles, then stream with ready held high
        tick();
        check("rst_valid", 32'(bus.Instr_valid_o), 32'd0);
        check("rst_instr", bus.Instruction_o, 32'd0);
        check("rst_pc",    bus.Pc_o, 32'd0);
        check("rst_fault", 32'(bus.Fault_o), 32'd0);
        check("rst_addr",  bus.Address_o, RESET_PC);
        tick();
        reset = 1'b0;
        check("s1_addr0", bus.Address_o, 32'h0040_0000);
        tick();
        check("s1_valid", 32'(bus.Instr_valid_o), 32'd1);
        check("s1_ins0",  bus.Instruction_o, 32'h2008_ffff);
        check("s1_pc0",   bus.Pc_o, 32'h0040_0000);
        tick();
        check("s1_ins1",  bus.Instruction_o, 32'h2009_0010);
        tick();
        check("s1_ins2",  bus.Instruction_o, 32'h200a_000a);
        tick();
        check("s1_ins3",  bus.Instruction_o, 32'h200b_0019);
        check("s1_pc3",   bus.Pc_o, 32'h0040_000c);

        // Back-pressure right after reset: FIFO fills, PC holds
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        bus.Instr_ready_i = 1'b0;
        tick();
        tick();
        tick();
        check("s2_addr_hold3", bus.Address_o, 32'h0040_0008);
        tick();
        check("s2_addr_hold4", bus.Address_o, 32'h0040_0008);
        check("s2_valid",      32'(bus.Instr_valid_o), 32'd1);
        check("s2_head_pc",    bus.Pc_o, 32'h0040_0000);
        bus.Instr_ready_i = 1'b1;
        check("s2_ins0", bus.Instruction_o, 32'h2008_ffff);
        tick();
        check("s2_ins1", bus.Instruction_o, 32'h2009_0010);
        tick();
        check("s2_ins2", bus.Instruction_o, 32'h200a_000a);

        // Redirect while full (unaligned target)
        bus.Instr_ready_i = 1'b0;
        tick();
        tick();
        check("s3_full_valid", 32'(bus.Instr_valid_o), 32'd1);
        bus.Redirect_i = 1'b1;
        bus.Target_i   = 32'h0040_0012;
        tick();
        bus.Redirect_i = 1'b0;
        check("s3_valid_flush", 32'(bus.Instr_valid_o), 32'd0);
        check("s3_addr",        bus.Address_o, 32'h0040_0010);
        bus.Instr_ready_i = 1'b1;
        tick();
        check("s3_valid", 32'(bus.Instr_valid_o), 32'd1);
        check("s3_ins",   bus.Instruction_o, 32'h012a_8020);
        check("s3_pc",    bus.Pc_o, 32'h0040_0010);

`ifdef FETCH_BOUNDS_CHECK_EN
        // Out-of-range redirect faults and stops fetching; in-range clears it
        bus.Redirect_i = 1'b1;
        bus.Target_i   = 32'h0040_0100;
        tick();
        bus.Redirect_i = 1'b0;
        check("s4_fault_set", 32'(bus.Fault_o), 32'd1);
        check("s4_valid0",    32'(bus.Instr_valid_o), 32'd0);
        tick();
        tick();
        check("s4_fault_sticky", 32'(bus.Fault_o), 32'd1);
        check("s4_valid_stays",  32'(bus.Instr_valid_o), 32'd0);
        check("s4_addr_hold",    bus.Address_o, 32'h0040_0100);
        bus.Redirect_i = 1'b1;
        bus.Target_i   = 32'h0040_0014;
        tick();
        bus.Redirect_i = 1'b0;
        check("s4_fault_clr", 32'(bus.Fault_o), 32'd0);
        tick();
        check("s4_valid", 32'(bus.Instr_valid_o), 32'd1);
        check("s4_ins",   bus.Instruction_o, 32'h0168_8820);
`else
        // Fetch continues past the end of the ROM window without a fault
        bus.Redirect_i = 1'b1;
        bus.Target_i   = 32'h0040_00fc;
        tick();
        bus.Redirect_i = 1'b0;
        check("s4_addr_fc", bus.Address_o, 32'h0040_00fc);
        tick();
        check("s4_pc_fc",    bus.Pc_o, 32'h0040_00fc);
        check("s4_ins_fc",   bus.Instruction_o, 32'hA500_003f);
        check("s4_addr_100", bus.Address_o, 32'h0040_0100);
        tick();
        check("s4_pc_100",   bus.Pc_o, 32'h0040_0100);
        check("s4_ins_100",  bus.Instruction_o, 32'h2008_ffff);
        check("s4_fault",    32'(bus.Fault_o), 32'd0);
`endif

        // Reset and redirect together while full: reset wins
        bus.Instr_ready_i = 1'b0;
        tick();
        tick();
        tick();
        reset          = 1'b1;
        bus.Redirect_i = 1'b1;
        bus.Target_i   = 32'h0040_0040;
        tick();
        reset          = 1'b0;
        bus.Redirect_i = 1'b0;
        check("s5_valid", 32'(bus.Instr_valid_o), 32'd0);
        check("s5_ins",   bus.Instruction_o, 32'd0);
        check("s5_pc",    bus.Pc_o, 32'd0);
        check("s5_addr",  bus.Address_o, 32'h0040_0000);
        bus.Instr_ready_i = 1'b1;
        tick();
        check("s5_first_pc",  bus.Pc_o, 32'h0040_0000);
        check("s5_first_ins", bus.Instruction_o, 32'h2008_ffff);

        // Random back-pressure and redirects; scoreboard checks order
        for (int n = 0; n < 400; n++) begin
            bus.Instr_ready_i = ($urandom_range(0, 3) != 0);
            bus.Redirect_i    = ($urandom_range(0, 15) == 0);
            bus.Target_i      = RESET_PC + 32'($urandom_range(0, 200));
            tick();
        end
        bus.Redirect_i    = 1'b0;
        bus.Instr_ready_i = 1'b1;
        tick();
        tick();
        tick();

        check("sb_activity", (pops > 150) ? 32'd1 : 32'd0, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter MEMORY_DEPTH, default 64, number of 32-bit words in the instruction ROM.
REQ-002 Parameter DATA_WIDTH, default 32, width of addresses and instructions.
REQ-003 Parameter RESET_PC, default 32'h0040_0000, PC loaded at reset; base address of the ROM.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 Address_o  output  DATA_WIDTH  byte address driven to ROM Address_i; always equals current PC.
REQ-007 Instruction_i  input  DATA_WIDTH  ROM Instruction_o; combinational, valid in the same cycle as Address_o.
REQ-008 Redirect_i  input  1  branch/jump request; 1-cycle pulse.
REQ-009 Target_i  input  DATA_WIDTH  redirect target byte address, sampled when Redirect_i=1.
REQ-010 Instr_valid_o  output  1  head instruction available to decoder.
REQ-011 Instr_ready_i  input  1  decoder accepts head instruction.
REQ-012 Instruction_o  output  DATA_WIDTH  head instruction word.
REQ-013 Pc_o  output  DATA_WIDTH  byte address of Instruction_o.
REQ-014 Fault_o  output  1  out-of-range fetch flag (see Configuration).

Function
REQ-015 Block SHALL hold PC register and 2-entry FIFO of {PC, instruction} pairs; count states EMPTY(0), ONE(1), FULL(2).
REQ-016 Push SHALL occur in a cycle when Redirect_i=0, no fault, and (count<2 or a pop occurs in the same cycle); push stores {PC, Instruction_i} and sets PC<=PC+4.
REQ-017 Pop SHALL occur when Instr_valid_o=1 and Instr_ready_i=1; Instr_valid_o=1 iff count>0.
REQ-018 Simultaneous push and pop SHALL leave count unchanged; FULL with pop SHALL still push (1 instruction/cycle throughput).
REQ-019 Latency: instruction fetched in cycle N SHALL appear on Instruction_o/Pc_o in cycle N+1 at the earliest.
REQ-020 When Instr_valid_o=0, Instruction_o and Pc_o SHALL be 0.
REQ-021 When FULL and no pop, PC and Address_o SHALL hold; no instruction lost or duplicated.
REQ-022 Redirect_i=1 SHALL have priority: FIFO flushed to EMPTY, no push, PC<=Target_i with bits[1:0] forced to 0; a head handshake in that same cycle counts as consumed.
REQ-023 PC+4 SHALL wrap modulo 2^DATA_WIDTH.

Reset
REQ-024 reset=1 SHALL set PC=RESET_PC, count=0, Instr_valid_o=0, Instruction_o=0, Pc_o=0, Fault_o=0; Address_o=RESET_PC in the cycle after the reset edge.
REQ-025 reset asserted mid-operation SHALL discard FIFO contents and pending redirect; reset overrides Redirect_i.

Configuration
REQ-026 Macro FETCH_BOUNDS_CHECK_EN defined: PC outside [RESET_PC, RESET_PC+4*MEMORY_DEPTH) SHALL block push and set Fault_o=1 (registered, sticky) until reset or a redirect to an in-range target; FIFO entries already held still drain.
REQ-027 Macro undefined: Fault_o SHALL be tied 0; out-of-range PCs fetch normally (ROM decodes low address bits).

Verification
REQ-028 Reset 2 cycles, release, Instr_ready_i=1 -> Address_o=0x0040_0000; next cycle Instr_valid_o=1, Instruction_o=0x2008ffff, Pc_o=0x0040_0000; then 0x20090010, 0x200a000a, 0x200b0019 on consecutive cycles.
REQ-029 Instr_ready_i=0 for 4 cycles after reset -> count reaches 2, Address_o holds 0x0040_0008; on release, outputs 0x2008ffff, 0x20090010, 0x200a000a in order, none skipped.
REQ-030 Redirect_i=1, Target_i=0x0040_0012 while FULL -> next cycle Instr_valid_o=0, Address_o=0x0040_0010; following cycle Instruction_o=0x012a8020, Pc_o=0x0040_0010.
REQ-031 With FETCH_BOUNDS_CHECK_EN, MEMORY_DEPTH=64: redirect to 0x0040_0100 -> Fault_o=1 next cycle, Instr_valid_o stays 0; redirect to 0x0040_0014 -> Fault_o=0, Instruction_o=0x01688820.
REQ-032 reset asserted with count=2 and Redirect_i=1 in the same cycle -> next cycle Instr_valid_o=0, Instruction_o=0, Pc_o=0, Address_o=0x0040_0000.
REQ-033 PC at 0x0040_00FC, ready=1, macro undefined -> fetch continues to 0x0040_0100, Fault_o stays 0.
